span_decoder: RTL and testbench

SPAN_DECODER -- requirements
Module: span_decoder

---
 rtl/span_decoder_if.sv | 34 +++
 rtl/span_decoder.sv | 134 +++++++++++++
 tb/tb_span_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/span_decoder_if.sv
// Handshake bundle for span_decoder.
//   upstream   : data_left_i / data_right_i / data_val_i -> data_rdy_o
//   mask out   : mask_o qualified by the one-cycle mask_val_o strobe
//   beat stream: idx_o / idx_val_o / idx_last_o -> idx_rdy_i
//   error      : err_o one-cycle strobe for a rejected pair
// Modports: master = the side driving pairs and consuming beats,
//           slave  = the decoder itself.
interface span_decoder_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] data_left_i;
    logic [WIDTH-1:0] data_right_i;
    logic             data_val_i;
    logic             data_rdy_o;
    logic [WIDTH-1:0] mask_o;
    logic             mask_val_o;
    logic [IDX_W-1:0] idx_o;
    logic             idx_val_o;
    logic             idx_last_o;
    logic             idx_rdy_i;
    logic             err_o;

    modport master (
        output data_left_i, data_right_i, data_val_i, idx_rdy_i,
        input  data_rdy_o, mask_o, mask_val_o, idx_o, idx_val_o, idx_last_o, err_o
    );

    modport slave (
        input  data_left_i, data_right_i, data_val_i, idx_rdy_i,
        output data_rdy_o, mask_o, mask_val_o, idx_o, idx_val_o, idx_last_o, err_o
    );
endinterface

// File: rtl/span_decoder.sv
// span_decoder: takes a pair of one-hot masks marking the highest (left) and
// lowest (right) set bits of a word, rebuilds the contiguous span mask and
// streams the bit indices of the span from right to left, one per accepted beat.
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous active-low reset
//   bus     - span_decoder_if.slave (pair input, mask output, index stream, error)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a pair (data_rdy_o = 1); no beat presented
// ST_RUN  | streaming idx_o from R up to L; incoming pairs are ignored
module span_decoder #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    span_decoder_if.slave bus
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mask;
    logic             r_mask_val;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_left_idx;
    logic             r_err;

    logic             w_accept;
    logic             w_legal;
    logic             w_left_oh;
    logic             w_right_oh;
    logic [IDX_W-1:0] w_left_idx;
    logic [IDX_W-1:0] w_right_idx;
    logic [WIDTH-1:0] w_span;
    logic             w_last;
    logic             w_load;
    logic             w_step;
    logic             w_err_nxt;

    assign w_left_oh  = (bus.data_left_i  != '0) && ((bus.data_left_i  & (bus.data_left_i  - 1'b1)) == '0);
    assign w_right_oh = (bus.data_right_i != '0) && ((bus.data_right_i & (bus.data_right_i - 1'b1)) == '0);

    // For one-hot operands, comparing the masks as numbers orders the bit positions.
    assign w_legal  = w_left_oh && w_right_oh && (bus.data_right_i <= bus.data_left_i);
    assign w_accept = bus.data_val_i && (r_state == ST_IDLE);

    // left - right fills bits R..L-1; OR-ing left back in adds bit L (and covers L = R).
    assign w_span = (bus.data_left_i - bus.data_right_i) | bus.data_left_i;

    always_comb begin
        w_left_idx  = '0;
        w_right_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.data_left_i[i])  w_left_idx  = IDX_W'(i);
            if (bus.data_right_i[i]) w_right_idx = IDX_W'(i);
        end
    end

    assign w_last = (r_state == ST_RUN) && (r_idx == r_left_idx);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_state_nxt = ST_RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.idx_rdy_i) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stepping stops at L, so r_idx can never pass WIDTH-1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mask     <= '0;
            r_mask_val <= 1'b0;
            r_idx      <= '0;
            r_left_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            r_mask_val <= w_load;
            r_err      <= w_err_nxt;
            if (w_load) begin
                r_mask     <= w_span;
                r_idx      <= w_right_idx;
                r_left_idx <= w_left_idx;
            end else if (w_step) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign bus.data_rdy_o = (r_state == ST_IDLE);
    assign bus.mask_o     = r_mask;
    assign bus.mask_val_o = r_mask_val;
    assign bus.idx_o      = r_idx;
    assign bus.idx_val_o  = (r_state == ST_RUN);
    assign bus.idx_last_o = w_last;
    assign bus.err_o      = r_err;

endmodule

// File: tb/tb_span_decoder.sv
module tb_span_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    span_decoder_if #(.WIDTH(8)) u_if ();

    span_decoder #(.WIDTH(8)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"},      u_if.data_rdy_o, 1);
        check({tag, "_idx_val"},  u_if.idx_val_o,  0);
        check({tag, "_idx_last"}, u_if.idx_last_o, 0);
        check({tag, "_mask_val"}, u_if.mask_val_o, 0);
        check({tag, "_err"},      u_if.err_o,      0);
    endtask

    // Offers one pair and walks the expected beats lo..hi.
    // stall_at/stall_n: hold idx_rdy_i low for stall_n cycles on beat stall_at.
    // inj_at: offer a different pair on that beat (must be ignored).
    // abort_at: return at the sample point of that beat without transferring it.
    task automatic run_stream(input string tag, input logic [7:0] left, input logic [7:0] right,
                              input logic [7:0] exp_mask, input int lo, input int hi,
                              input int stall_at, input int stall_n, input int inj_at,
                              input int abort_at);
        bit first = 1'b1;
        u_if.data_left_i  = left;
        u_if.data_right_i = right;
        u_if.data_val_i   = 1'b1;
        u_if.idx_rdy_i    = 1'b1;
        tick();
        u_if.data_val_i = 1'b0;
        for (int k = lo; k <= hi; k++) begin
            if (k == abort_at) return;
            check({tag, "_mask_val"}, u_if.mask_val_o, first);
            if (first) check({tag, "_mask"}, u_if.mask_o, exp_mask);
            first = 1'b0;
            check({tag, "_idx"},      u_if.idx_o,      k);
            check({tag, "_idx_val"},  u_if.idx_val_o,  1);
            check({tag, "_idx_last"}, u_if.idx_last_o, (k == hi));
            check({tag, "_rdy"},      u_if.data_rdy_o, 0);
            check({tag, "_err"},      u_if.err_o,      0);
            if (k == inj_at) begin
                u_if.data_left_i  = 8'h04;
                u_if.data_right_i = 8'h01;
                u_if.data_val_i   = 1'b1;
            end
            if (k == stall_at) begin
                u_if.idx_rdy_i = 1'b0;
                repeat (stall_n) begin
                    tick();
                    u_if.data_val_i = 1'b0;
                    check({tag, "_stall_idx"},  u_if.idx_o,      k);
                    check({tag, "_stall_val"},  u_if.idx_val_o,  1);
                    check({tag, "_stall_last"}, u_if.idx_last_o, (k == hi));
                    check({tag, "_stall_mval"}, u_if.mask_val_o, 0);
                end
                u_if.idx_rdy_i = 1'b1;
            end
            tick();
            u_if.data_val_i = 1'b0;
        end
        check_idle({tag, "_end"});
        check({tag, "_mask_hold"}, u_if.mask_o, exp_mask);
    endtask

    task automatic bad_pair(input string tag, input logic [7:0] left, input logic [7:0] right,
                            input logic [7:0] prev_mask);
        u_if.data_left_i  = left;
        u_if.data_right_i = right;
        u_if.data_val_i   = 1'b1;
        tick();
        u_if.data_val_i = 1'b0;
        check({tag, "_err"},       u_if.err_o,      1);
        check({tag, "_mask_val"},  u_if.mask_val_o, 0);
        check({tag, "_idx_val"},   u_if.idx_val_o,  0);
        check({tag, "_rdy"},       u_if.data_rdy_o, 1);
        check({tag, "_mask_hold"}, u_if.mask_o,     prev_mask);
        tick();
        check({tag, "_err_drop"},  u_if.err_o,      0);
        check({tag, "_idx_val2"},  u_if.idx_val_o,  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        u_if.data_left_i  = '0;
        u_if.data_right_i = '0;
        u_if.data_val_i   = 1'b0;
        u_if.idx_rdy_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mask", u_if.mask_o, 0);
        check("rst_idx",  u_if.idx_o,  0);
        check_idle("rst");
        rst_n = 1'b1;

        run_stream("span36", 8'h40, 8'h08, 8'h78, 3, 6, -1, 0, -1, -1);
        run_stream("single7", 8'h80, 8'h80, 8'h80, 7, 7, -1, 0, -1, -1);
        run_stream("stall", 8'h40, 8'h08, 8'h78, 3, 6, 4, 2, -1, -1);
        bad_pair("bad_order", 8'h01, 8'h80, 8'h78);
        bad_pair("bad_onehot", 8'h60, 8'h01, 8'h78);
        bad_pair("bad_zero", 8'h10, 8'h00, 8'h78);
        run_stream("inject", 8'h40, 8'h08, 8'h78, 3, 6, -1, 0, 4, -1);
        run_stream("full", 8'h80, 8'h01, 8'hFF, 0, 7, 7, 1, 0, -1);

        run_stream("abort", 8'h40, 8'h08, 8'h78, 3, 6, -1, 0, -1, 5);
        check("abort_pre_idx", u_if.idx_o, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mask",     u_if.mask_o,     0);
        check("arst_mask_val", u_if.mask_val_o, 0);
        check("arst_idx",      u_if.idx_o,      0);
        check("arst_idx_val",  u_if.idx_val_o,  0);
        check("arst_idx_last", u_if.idx_last_o, 0);
        check("arst_err",      u_if.err_o,      0);
        check("arst_rdy",      u_if.data_rdy_o, 1);
        u_if.data_left_i  = 8'h02;
        u_if.data_right_i = 8'h02;
        u_if.data_val_i   = 1'b1;
        tick();
        check("inrst_idx_val", u_if.idx_val_o, 0);
        check("inrst_mask",    u_if.mask_o,    0);
        check("inrst_rdy",     u_if.data_rdy_o, 1);
        #2;
        rst_n = 1'b1;
        run_stream("after_rst", 8'h02, 8'h02, 8'h02, 1, 1, -1, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
